// File: rtl/result_writer.sv
// Streams per-lane kernel result bytes into consecutive memory byte slots, then
// commands the memory to dump its contents and pulses done.
module result_writer #(
    parameter int unsigned nkernel = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             base_addr,
    input  logic [9:0]             count,
    input  logic                   in_valid,
    input  logic [8*nkernel-1:0]   data_in,
    output logic                   in_ready,
    output logic [7:0]             address,
    output logic [1:0]             offset,
    output logic                   write,
    output logic [8*nkernel-1:0]   in,
    output logic                   writeOut,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StFlush,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [6:0]           wptr_q, wptr_d;
    logic [1:0]           boff_q, boff_d;
    logic [9:0]           rem_q, rem_d;
    logic                 write_q;
    logic [7:0]           address_q;
    logic [1:0]           offset_q;
    logic [8*nkernel-1:0] in_q;
    logic                 accept;

    assign accept = (state_q == StRun) && in_valid;

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        boff_d   = boff_q;
        rem_d    = rem_q;
        in_ready = 1'b0;
        writeOut = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (count != 10'd0) begin
                        // The memory holds 128 words, so the top address bit is dropped.
                        wptr_d  = base_addr[6:0];
                        boff_d  = 2'd0;
                        rem_d   = count;
                        state_d = StRun;
                    end else begin
                        state_d = StFlush;
                    end
                end
            end
            StRun: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    boff_d = boff_q + 2'd1;
                    if (boff_q == 2'd3) begin
                        wptr_d = wptr_q + 7'd1;
                    end
                    rem_d = rem_q - 10'd1;
                    if (rem_q == 10'd1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                state_d = StFlush;
            end
            StFlush: begin
                writeOut = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            wptr_q    <= 7'd0;
            boff_q    <= 2'd0;
            rem_q     <= 10'd0;
            write_q   <= 1'b0;
            address_q <= 8'd0;
            offset_q  <= 2'd0;
            in_q      <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            boff_q  <= boff_d;
            rem_q   <= rem_d;
            write_q <= accept;
            if (accept) begin
                address_q <= {1'b0, wptr_q};
                offset_q  <= boff_q;
                in_q      <= data_in;
            end
        end
    end

    assign busy    = (state_q != StIdle);
    assign write   = write_q;
    assign address = address_q;
    assign offset  = offset_q;
    assign in      = in_q;

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer: stimulus pushes expected strobes with their
// cycle stamps, a negedge monitor pops and compares them.
module tb_result_writer;

    localparam int NK = 4;
    localparam int DW = 8 * NK;

    logic          clock, reset, start, in_valid;
    logic [7:0]    base_addr;
    logic [9:0]    count;
    logic [DW-1:0] data_in;
    logic          in_ready, write, writeOut, busy, done;
    logic [7:0]    address;
    logic [1:0]    offset;
    logic [DW-1:0] in;

    result_writer #(.nkernel(NK)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .in_valid (in_valid),
        .data_in  (data_in),
        .in_ready (in_ready),
        .address  (address),
        .offset   (offset),
        .write    (write),
        .in       (in),
        .writeOut (writeOut),
        .busy     (busy),
        .done     (done)
    );

    // kind: 0 = write, 1 = writeOut, 2 = done
    typedef struct {
        int            kind;
        int            cyc;
        logic [7:0]    addr;
        logic [1:0]    off;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    int            job = 0;
    logic [7:0]    last_addr = '0;
    logic [1:0]    last_off = '0;
    logic [DW-1:0] last_data = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int kind, input int c, input logic [7:0] a, input logic [1:0] o,
                        input logic [DW-1:0] d);
        exp_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.off = o; e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the scoreboard, and the write
    // fields must hold between write pulses.
    always @(negedge clock) begin
        if (!reset) begin
            int   nstb;
            int   kind;
            exp_t e;
            nstb = int'(write) + int'(writeOut) + int'(done);
            if (nstb > 1) begin
                check("strobe_overlap", 64'(nstb), 64'd1);
            end else if (nstb == 1) begin
                kind = write ? 0 : (writeOut ? 1 : 2);
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 64'(kind), 64'hFF);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind", 64'(kind), 64'(e.kind));
                    check("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.kind == 0) begin
                        check("wr_addr", 64'(address), 64'(e.addr));
                        check("wr_off", 64'(offset), 64'(e.off));
                        check("wr_data", 64'(in), 64'(e.data));
                        last_addr = e.addr;
                        last_off  = e.off;
                        last_data = e.data;
                    end
                end
            end
            if (!write) begin
                check("hold_fields", {address, offset, in}, {last_addr, last_off, last_data});
            end
        end
    end

    // Runs one job; toggle inserts an idle cycle after each byte, poke fires a
    // conflicting start during RUN that must be ignored.
    task automatic do_job(input logic [7:0] base, input int cnt, input bit toggle, input bit poke);
        logic [6:0]    wptr;
        logic [1:0]    boff;
        logic [DW-1:0] d;
        int            n;
        int            c;
        job++;
        start = 1'b1; base_addr = base; count = 10'(cnt);
        tick();
        start = 1'b0; base_addr = 8'hEE; count = 10'h3FF;
        if (cnt == 0) begin
            c = cyc;
            push(1, c, '0, '0, '0);
            push(2, c + 1, '0, '0, '0);
            tick();
            tick();
            return;
        end
        wptr = base[6:0];
        boff = 2'd0;
        n = 0;
        while (n < cnt) begin
            if (toggle && n > 0 && in_valid) begin
                in_valid = 1'b0;
                data_in  = 32'hDEAD_BEEF;
                tick();
            end else begin
                d = DW'(32'hA5C3_0F00 ^ ((job << 16) | n));
                in_valid = 1'b1;
                data_in  = d;
                if (poke && n == 1) begin
                    start = 1'b1; base_addr = 8'h55; count = 10'd7;
                end
                tick();
                start = 1'b0;
                push(0, cyc, {1'b0, wptr}, boff, d);
                if (boff == 2'd3) wptr = wptr + 7'd1;
                boff = boff + 2'd1;
                n++;
            end
        end
        in_valid = 1'b0;
        c = cyc;
        push(1, c + 1, '0, '0, '0);
        push(2, c + 2, '0, '0, '0);
        repeat (3) tick();
        check("idle_after_job", {busy, in_ready}, 2'b00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, {write, writeOut, done, busy, in_ready}, 5'b0);
        check({tag, "_fields"}, {address, offset, in}, '0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        base_addr = '0; count = '0; data_in = '0;
        #3;
        check_reset_outputs("reset_init");
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("idle_ready", {busy, in_ready}, 2'b00);

        do_job(8'h10, 6, 1'b0, 1'b0);   // (10,0..3),(11,0..1)
        do_job(8'h30, 4, 1'b1, 1'b0);   // gapped accepts
        do_job(8'd127, 5, 1'b0, 1'b0);  // wrap 127 -> 0
        do_job(8'h22, 0, 1'b0, 1'b0);   // empty job
        do_job(8'h85, 3, 1'b0, 1'b0);   // base reduced to word 5

        // Abort after 3 of 8 accepts.
        job++;
        start = 1'b1; base_addr = 8'h60; count = 10'd8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            data_in  = DW'(32'h1111_1111 * (i + 1));
            tick();
            push(0, cyc, 8'h60, 2'(i), data_in);
        end
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_mid");
        in_valid = 1'b0;
        last_addr = '0; last_off = '0; last_data = '0;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("idle_post_abort", {busy, in_ready}, 2'b00);

        do_job(8'h44, 2, 1'b0, 1'b0);   // fresh job from its own base
        do_job(8'h08, 4, 1'b0, 1'b1);   // start during RUN ignored

        repeat (2) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
